cmd_sequencer: RTL

CMD_SEQUENCER -- requirements
Module: cmd_sequencer

---
 rtl/cmd_sequencer.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/cmd_sequencer.sv
// Command sequencer: queues host opcodes in a small FIFO and issues them one at a
// time to an engine controller, returning a completion record per command.
module cmd_sequencer #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_op,
  output logic             cmd_ready,
  output logic [1:0]       opcode,
  output logic             start,
  input  logic             finish,
  output logic             busy,
  output logic             done_valid,
  output logic [1:0]       done_op,
  output logic             done_err,
  input  logic             done_ready,
  output logic [CNT_W-1:0] op_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int WW = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]        opcode_q, opcode_d;
  logic [WW-1:0]     wait_cnt_q, wait_cnt_d;
  logic              done_valid_q, done_valid_d;
  logic [1:0]        done_op_q, done_op_d;
  logic              done_err_q, done_err_d;
  logic [CNT_W-1:0]  op_cnt_q, op_cnt_d;

  logic fifo_empty_s;
  logic fifo_full_s;
  logic push_s;
  logic pop_s;
  logic wait_hit_s;
  logic wait_end_s;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign fifo_empty_s = (wr_ptr_q == rd_ptr_q);
  assign fifo_full_s  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_s       = cmd_valid && !fifo_full_s;
  assign pop_s        = (state_q == S_IDLE) && !fifo_empty_s && !done_valid_q;
  assign wait_hit_s   = (wait_cnt_q == WW'(TIMEOUT - 1));
  assign wait_end_s   = (state_q == S_WAIT) && (finish || wait_hit_s);

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= cmd_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      opcode_q     <= 2'b00;
      wait_cnt_q   <= '0;
      done_valid_q <= 1'b0;
      done_op_q    <= 2'b00;
      done_err_q   <= 1'b0;
      op_cnt_q     <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      opcode_q     <= opcode_d;
      wait_cnt_q   <= wait_cnt_d;
      done_valid_q <= done_valid_d;
      done_op_q    <= done_op_d;
      done_err_q   <= done_err_d;
      op_cnt_q     <= op_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = pop_s ? S_LOAD : S_IDLE;
      S_LOAD:  state_d = S_START;
      S_START: state_d = S_WAIT;
      S_WAIT:  state_d = wait_end_s ? S_GAP : S_WAIT;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start = (state_q == S_START);
    busy  = (state_q != S_IDLE);
  end

  // A new record can only be produced after the previous one was taken, since IDLE
  // refuses to pop while done_valid is high; setting it still has priority.
  always_comb begin
    wr_ptr_d     = push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d     = pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    opcode_d     = pop_s ? mem_q[rd_ptr_q[AW-1:0]] : opcode_q;
    wait_cnt_d   = wait_cnt_q;
    done_valid_d = done_valid_q;
    done_op_d    = done_op_q;
    done_err_d   = done_err_q;
    op_cnt_d     = op_cnt_q;
    if (state_q == S_START) begin
      wait_cnt_d = '0;
    end else if (state_q == S_WAIT) begin
      wait_cnt_d = wait_cnt_q + WW'(1);
    end else begin
      wait_cnt_d = wait_cnt_q;
    end
    if (done_valid_q && done_ready) begin
      done_valid_d = 1'b0;
    end else begin
      done_valid_d = done_valid_q;
    end
    if (wait_end_s) begin
      done_valid_d = 1'b1;
      done_op_d    = opcode_q;
      done_err_d   = !finish;
    end else begin
      done_op_d    = done_op_q;
    end
    if ((state_q == S_WAIT) && finish) begin
      op_cnt_d = op_cnt_q + CNT_W'(1);
    end else begin
      op_cnt_d = op_cnt_q;
    end
  end

  assign cmd_ready  = !fifo_full_s;
  assign opcode     = opcode_q;
  assign done_valid = done_valid_q;
  assign done_op    = done_op_q;
  assign done_err   = done_err_q;
  assign op_cnt     = op_cnt_q;

endmodule
